// File: rtl/iob_ddr_rst_seq.sv
// DDR bring-up and system-reset sequencer: holds the SoC in reset until the DDR PLL locks and
// calibration succeeds, retries the controller on failure/timeout and restarts on loss of lock.
module iob_ddr_rst_seq #(
  parameter int unsigned CTRL_RST_CYC = 16,
  parameter int unsigned TIMEOUT_CYC  = 1000000,
  parameter int unsigned STRETCH_CYC  = 256,
  parameter int unsigned MAX_RETRY    = 3  // must be <= 3 to fit retry_cnt_o
) (
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       locked_i,
  input  logic       init_done_i,
  input  logic       cal_success_i,
  input  logic       cal_fail_i,
  output logic       ddr_rst_n_o,
  output logic       sys_rst_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt_o
);

  localparam int unsigned CtrlW  = $clog2(CTRL_RST_CYC + 1);
  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned StrW   = $clog2(STRETCH_CYC + 1);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    StCtrlRst = 3'd0,
    StPllWait = 3'd1,
    StCalWait = 3'd2,
    StStretch = 3'd3,
    StRun     = 3'd4,
    StFail    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CtrlW-1:0]    ctrl_cnt_q, ctrl_cnt_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [StrW-1:0]     str_cnt_q, str_cnt_d;
  logic [RetryW-1:0]   retry_cnt_q, retry_cnt_d;
  logic                sys_rst_q, sys_rst_d;
  logic                ddr_rst_n_q, ddr_rst_n_d;
  logic [3:0]          sync1_q, sync2_q;

  logic locked_s, init_done_s, cal_success_s, cal_fail_s;
  logic ctrl_done, tmo_hit, str_done, do_retry, loss;
  logic in_wait_q, in_wait_d;

  assign locked_s      = sync2_q[0];
  assign init_done_s   = sync2_q[1];
  assign cal_success_s = sync2_q[2];
  assign cal_fail_s    = sync2_q[3];

  assign ctrl_done = (ctrl_cnt_q == CtrlW'(CTRL_RST_CYC - 1));
  assign tmo_hit   = (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));
  assign str_done  = (str_cnt_q == StrW'(STRETCH_CYC - 1));
  assign loss      = !locked_s || !init_done_s;

  // State register, counters, synchronizers and the glitch-free reset output flops.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= StCtrlRst;
      ctrl_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      str_cnt_q   <= '0;
      retry_cnt_q <= '0;
      sys_rst_q   <= 1'b1;
      ddr_rst_n_q <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_cnt_q  <= ctrl_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      str_cnt_q   <= str_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      sys_rst_q   <= sys_rst_d;
      ddr_rst_n_q <= ddr_rst_n_d;
      sync1_q     <= {cal_fail_i, cal_success_i, init_done_i, locked_i};
      sync2_q     <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    do_retry    = 1'b0;
    unique case (state_q)
      StCtrlRst: if (ctrl_done) state_d = StPllWait;
      StPllWait: begin
        if (tmo_hit) begin
          do_retry = 1'b1;
        end else if (locked_s) begin
          state_d = StCalWait;
        end
      end
      StCalWait: begin
        // Fail has priority over a simultaneous success.
        if (cal_fail_s || !locked_s || tmo_hit) begin
          do_retry = 1'b1;
        end else if (init_done_s && cal_success_s) begin
          state_d = StStretch;
        end
      end
      StStretch: begin
        if (loss) begin
          state_d     = StCtrlRst;
          retry_cnt_d = '0;
        end else if (str_done) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (loss) begin
          state_d     = StCtrlRst;
          retry_cnt_d = '0;
        end
      end
      StFail:  state_d = StFail;
      default: state_d = StCtrlRst;
    endcase

    if (do_retry) begin
      if (retry_cnt_q < RetryW'(MAX_RETRY)) begin
        retry_cnt_d = retry_cnt_q + 1'b1;
        state_d     = StCtrlRst;
      end else begin
        state_d = StFail;
      end
    end

    // Counters only run while the state is held, so each restarts from zero on entry.
    in_wait_q  = (state_q == StPllWait) || (state_q == StCalWait);
    in_wait_d  = (state_d == StPllWait) || (state_d == StCalWait);
    ctrl_cnt_d = (state_q == StCtrlRst && state_d == StCtrlRst) ? ctrl_cnt_q + 1'b1 : '0;
    tmo_cnt_d  = (in_wait_q && in_wait_d) ? tmo_cnt_q + 1'b1 : '0;
    str_cnt_d  = (state_q == StStretch && state_d == StStretch) ? str_cnt_q + 1'b1 : '0;

    sys_rst_d   = (state_d != StRun);
    ddr_rst_n_d = (state_d != StCtrlRst) && (state_d != StFail);
  end

  always_comb begin
    fail_o      = (state_q == StFail);
    state_o     = state_q;
    retry_cnt_o = 2'(retry_cnt_q);
    sys_rst_o   = sys_rst_q;
    ddr_rst_n_o = ddr_rst_n_q;
  end

endmodule

// File: tb/tb_iob_ddr_rst_seq.sv
// Bench for iob_ddr_rst_seq: directed bring-up scenarios plus randomized status inputs checked
// every cycle against a timestamp-based behavioural model.
module tb_iob_ddr_rst_seq;

  localparam int Crc = 4;
  localparam int Tmo = 100;
  localparam int Str = 8;
  localparam int Mr  = 2;

  logic       clk_i         = 1'b0;
  logic       arstn_i       = 1'b0;
  logic       locked_i      = 1'b0;
  logic       init_done_i   = 1'b0;
  logic       cal_success_i = 1'b0;
  logic       cal_fail_i    = 1'b0;
  logic       ddr_rst_n_o;
  logic       sys_rst_o;
  logic       fail_o;
  logic [2:0] state_o;
  logic [1:0] retry_cnt_o;

  iob_ddr_rst_seq #(
    .CTRL_RST_CYC(Crc),
    .TIMEOUT_CYC (Tmo),
    .STRETCH_CYC (Str),
    .MAX_RETRY   (Mr)
  ) u_dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .locked_i     (locked_i),
    .init_done_i  (init_done_i),
    .cal_success_i(cal_success_i),
    .cal_fail_i   (cal_fail_i),
    .ddr_rst_n_o  (ddr_rst_n_o),
    .sys_rst_o    (sys_rst_o),
    .fail_o       (fail_o),
    .state_o      (state_o),
    .retry_cnt_o  (retry_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phases are timed by edge timestamps; status inputs are seen two edges late.
  int         m_phase      = 0;
  int         m_retries    = 0;
  int         m_edge       = 0;
  int         m_enter      = 0;
  int         m_wait_start = 0;
  logic [3:0] m_h1         = '0;
  logic [3:0] m_h2         = '0;
  logic       m_lk, m_id, m_cs, m_cf;

  task automatic model_retry();
    if (m_retries < Mr) begin
      m_retries++;
      m_phase = 0;
      m_enter = m_edge;
    end else begin
      m_phase = 5;
    end
  endtask

  task automatic model_restart();
    m_phase   = 0;
    m_enter   = m_edge;
    m_retries = 0;
  endtask

  always @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_phase   = 0;
      m_retries = 0;
      m_edge    = 0;
      m_enter   = 0;
      m_h1      = '0;
      m_h2      = '0;
    end else begin
      m_edge++;
      {m_cf, m_cs, m_id, m_lk} = m_h2;
      m_h2 = m_h1;
      m_h1 = {cal_fail_i, cal_success_i, init_done_i, locked_i};
      case (m_phase)
        0: if (m_edge - m_enter == Crc) begin
          m_phase      = 1;
          m_wait_start = m_edge;
        end
        1: begin
          if (m_edge - m_wait_start == Tmo) model_retry();
          else if (m_lk) m_phase = 2;
        end
        2: begin
          if (m_cf || !m_lk || (m_edge - m_wait_start == Tmo)) begin
            model_retry();
          end else if (m_id && m_cs) begin
            m_phase = 3;
            m_enter = m_edge;
          end
        end
        3: begin
          if (!m_lk || !m_id) model_restart();
          else if (m_edge - m_enter == Str) m_phase = 4;
        end
        4: if (!m_lk || !m_id) model_restart();
        default: ;
      endcase
    end
  end

  always @(negedge clk_i) begin
    check_eq("mon_sys_rst", int'(sys_rst_o), int'(m_phase != 4));
    check_eq("mon_ddr_rst_n", int'(ddr_rst_n_o), int'(m_phase != 0 && m_phase != 5));
    check_eq("mon_fail", int'(fail_o), int'(m_phase == 5));
    check_eq("mon_state", int'(state_o), m_phase);
    check_eq("mon_retry", int'(retry_cnt_o), m_retries);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Leaves the bench #1 after "edge 0"; the next rising edge is edge 1 after release.
  task automatic do_reset();
    arstn_i       = 1'b0;
    locked_i      = 1'b0;
    init_done_i   = 1'b0;
    cal_success_i = 1'b0;
    cal_fail_i    = 1'b0;
    step(2);
    arstn_i = 1'b1;
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    for (int i = 0; i < budget && int'(state_o) != st; i++) step();
    check_eq(tag, int'(state_o), st);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lock_den;

    // Reset values.
    do_reset();
    check_eq("rst_sys_rst", int'(sys_rst_o), 1);
    check_eq("rst_ddr_rst_n", int'(ddr_rst_n_o), 0);
    check_eq("rst_state", int'(state_o), 0);

    // Nominal bring-up.
    for (int e = 1; e <= 45; e++) begin
      step();
      if (e == 10) locked_i = 1'b1;
      if (e == 30) begin
        init_done_i   = 1'b1;
        cal_success_i = 1'b1;
      end
      if (e == 3) check_eq("nom_ddr_e3", int'(ddr_rst_n_o), 0);
      if (e == 4) check_eq("nom_ddr_e4", int'(ddr_rst_n_o), 1);
      if (e == 40) check_eq("nom_sys_e40", int'(sys_rst_o), 1);
      if (e == 41) begin
        check_eq("nom_sys_e41", int'(sys_rst_o), 0);
        check_eq("nom_state_e41", int'(state_o), 4);
      end
    end

    // Loss of lock in RUN, then full re-bring-up.
    locked_i = 1'b0;
    step(2);
    check_eq("loss_sys_e2", int'(sys_rst_o), 0);
    step();
    check_eq("loss_sys_e3", int'(sys_rst_o), 1);
    check_eq("loss_ddr_e3", int'(ddr_rst_n_o), 0);
    check_eq("loss_state_e3", int'(state_o), 0);
    check_eq("loss_retry_e3", int'(retry_cnt_o), 0);
    locked_i = 1'b1;
    wait_state(4, 200, "loss_rebringup");

    // Calibration failure on every attempt.
    do_reset();
    locked_i = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      wait_state(2, 200, "cf_reach_cal");
      cal_fail_i = 1'b1;
      step(3);
      cal_fail_i = 1'b0;
      if (a < 3) begin
        check_eq("cf_retry", int'(retry_cnt_o), a);
        check_eq("cf_state", int'(state_o), 0);
      end else begin
        check_eq("cf_fail", int'(fail_o), 1);
        check_eq("cf_fail_state", int'(state_o), 5);
        check_eq("cf_fail_sys", int'(sys_rst_o), 1);
        check_eq("cf_fail_ddr", int'(ddr_rst_n_o), 0);
      end
    end
    init_done_i   = 1'b1;
    cal_success_i = 1'b1;
    step(50);
    check_eq("cf_sticky", int'(state_o), 5);

    // Simultaneous fail and success counts as a failure.
    do_reset();
    locked_i = 1'b1;
    wait_state(2, 200, "sim_reach_cal");
    cal_fail_i    = 1'b1;
    cal_success_i = 1'b1;
    init_done_i   = 1'b1;
    step();
    cal_fail_i    = 1'b0;
    cal_success_i = 1'b0;
    step(3);
    check_eq("sim_retry", int'(retry_cnt_o), 1);
    check_eq("sim_state", int'(state_o), 0);

    // Timeout with the PLL never locking.
    do_reset();
    for (int e = 1; e <= 312; e++) begin
      step();
      if (e == 103) check_eq("tmo_e103", int'(state_o), 1);
      if (e == 104) begin
        check_eq("tmo_e104_state", int'(state_o), 0);
        check_eq("tmo_e104_retry", int'(retry_cnt_o), 1);
      end
      if (e == 311) check_eq("tmo_e311", int'(state_o), 1);
      if (e == 312) check_eq("tmo_e312", int'(state_o), 5);
    end

    // Asynchronous reset during STRETCH, checked between clock edges.
    do_reset();
    locked_i      = 1'b1;
    init_done_i   = 1'b1;
    cal_success_i = 1'b1;
    wait_state(3, 100, "ar_reach_stretch");
    #2;
    arstn_i = 1'b0;
    #1;
    check_eq("ar_sys_rst", int'(sys_rst_o), 1);
    check_eq("ar_ddr_rst_n", int'(ddr_rst_n_o), 0);
    check_eq("ar_state", int'(state_o), 0);
    check_eq("ar_fail", int'(fail_o), 0);
    step();

    // Randomized status inputs; the monitor compares against the model every cycle.
    for (int ep = 0; ep < 15; ep++) begin
      do_reset();
      lock_den = $urandom_range(3, 150);
      for (int c = 0; c < 500; c++) begin
        step();
        if (!locked_i) locked_i = ($urandom_range(0, lock_den) == 0);
        else if ($urandom_range(0, 399) == 0) locked_i = 1'b0;
        if (!init_done_i) init_done_i = locked_i && ($urandom_range(0, 19) == 0);
        else if ($urandom_range(0, 499) == 0) init_done_i = 1'b0;
        cal_success_i = init_done_i && (cal_success_i || ($urandom_range(0, 9) == 0));
        if (cal_fail_i) cal_fail_i = ($urandom_range(0, 2) != 0);
        else cal_fail_i = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 299) == 0) begin
          #2;
          arstn_i = 1'b0;
          step();
          arstn_i = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
